// File: rtl/board_ram_ctrl.sv
// ---------------------------------------------------------------------------
// board_ram_ctrl
//   Controller for the simple dual-port board/frame RAM. Everything runs on
//   clk_i, which also clocks both RAM ports.
//   - Write port: round-robin arbitration between requester A (game logic)
//     and requester B (display/host). A clear sweep can take over the port
//     and write CLEAR_VALUE to every address.
//   - Read port: pipelines read requests to the RAM and flags the returned
//     data two cycles after the request is presented.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   clear_start_i                  start a clear sweep (honoured only when idle)
//   clear_busy_o, clear_done_o     sweep in progress / one-cycle completion pulse
//   a_req_i, a_addr_i, a_data_i    requester A write request (held until granted)
//   a_gnt_o                        combinational grant to A
//   b_req_i, b_addr_i, b_data_i    requester B write request (held until granted)
//   b_gnt_o                        combinational grant to B
//   rd_req_i, rd_addr_i            read request, one per cycle
//   rd_valid_o, rd_data_o          read result (data passes straight from ram_q_i)
//   ram_we_o, ram_waddr_o,
//   ram_wdata_o, ram_raddr_o       registered RAM control
//   ram_q_i                        RAM read data
// ---------------------------------------------------------------------------
module board_ram_ctrl #(
  parameter int unsigned           DATA_WIDTH  = 7,
  parameter int unsigned           ADDR_WIDTH  = 9,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_start_i,
  output logic                  clear_busy_o,
  output logic                  clear_done_o,
  input  logic                  a_req_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  output logic                  a_gnt_o,
  input  logic                  b_req_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic                  b_gnt_o,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_waddr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  input  logic [DATA_WIDTH-1:0] ram_q_i
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  // The sweep ends on an explicit compare with the top address, so the
  // counter never needs to represent DEPTH and cannot wrap mid-sweep.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  done_q, done_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [1:0]            rd_pipe_q, rd_pipe_d;
  logic                  a_gnt, b_gnt;

  // Write-port arbitration, clear sweep sequencing and next-state logic.
  // A tie goes to whichever requester was not granted last; the sweep
  // blocks both requesters, which simply keep requesting until it ends.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    last_gnt_d = last_gnt_q;
    done_d     = 1'b0;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;

    if (state_q == ST_IDLE) begin
      if (a_req_i && (!b_req_i || (last_gnt_q == GNT_B))) begin
        a_gnt = 1'b1;
      end else if (b_req_i) begin
        b_gnt = 1'b1;
      end

      if (a_gnt) begin
        we_d       = 1'b1;
        waddr_d    = a_addr_i;
        wdata_d    = a_data_i;
        last_gnt_d = GNT_A;
      end else if (b_gnt) begin
        we_d       = 1'b1;
        waddr_d    = b_addr_i;
        wdata_d    = b_data_i;
        last_gnt_d = GNT_B;
      end

      // A grant taken in the same cycle still completes; the sweep's first
      // write follows it.
      if (clear_start_i) begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    end else begin
      we_d    = 1'b1;
      waddr_d = clr_cnt_q;
      wdata_d = CLEAR_VALUE;
      if (clr_cnt_q == LAST_ADDR) begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
        done_d    = 1'b1;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  // Read path: capture the address on request and shift a valid bit through
  // two stages to line up with the RAM's registered output.
  always_comb begin
    raddr_d   = rd_req_i ? rd_addr_i : raddr_q;
    rd_pipe_d = {rd_pipe_q[0], rd_req_i};
  end

  // State and output registers; reset parks the arbiter so A wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      clr_cnt_q  <= '0;
      last_gnt_q <= GNT_B;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      raddr_q    <= '0;
      rd_pipe_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      last_gnt_q <= last_gnt_d;
      done_q     <= done_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      raddr_q    <= raddr_d;
      rd_pipe_q  <= rd_pipe_d;
    end
  end

  assign a_gnt_o      = a_gnt;
  assign b_gnt_o      = b_gnt;
  assign clear_busy_o = (state_q == ST_CLEAR);
  assign clear_done_o = done_q;
  assign ram_we_o     = we_q;
  assign ram_waddr_o  = waddr_q;
  assign ram_wdata_o  = wdata_q;
  assign ram_raddr_o  = raddr_q;
  assign rd_valid_o   = rd_pipe_q[1];
  assign rd_data_o    = ram_q_i;

endmodule

// File: tb/tb_board_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_board_ram_ctrl
//   Self-checking bench for board_ram_ctrl. Includes a behavioural RAM with
//   old-data read behaviour and a reference memory image that tracks which
//   words the controller should have written.
// ---------------------------------------------------------------------------
module tb_board_ram_ctrl;

  localparam int DW    = 7;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_start_i;
  logic          clear_busy_o, clear_done_o;
  logic          a_req_i, b_req_i, a_gnt_o, b_gnt_o;
  logic [AW-1:0] a_addr_i, b_addr_i, rd_addr_i;
  logic [DW-1:0] a_data_i, b_data_i;
  logic          rd_req_i, rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_waddr_o, ram_raddr_o;
  logic [DW-1:0] ram_wdata_o, ram_q_i;

  board_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_VALUE('0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .clear_start_i(clear_start_i), .clear_busy_o(clear_busy_o), .clear_done_o(clear_done_o),
    .a_req_i(a_req_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_gnt_o(a_gnt_o),
    .b_req_i(b_req_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_gnt_o(b_gnt_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .ram_we_o(ram_we_o), .ram_waddr_o(ram_waddr_o), .ram_wdata_o(ram_wdata_o),
    .ram_raddr_o(ram_raddr_o), .ram_q_i(ram_q_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural simple dual-port RAM: a read of the address being written
  // returns the old word.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk_i) begin
    if (ram_we_o) ram_mem[ram_waddr_o] <= ram_wdata_o;
    ram_q_i <= ram_mem[ram_raddr_o];
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Observation logs; tests compare slices of these against expectations.
  logic [AW+DW-1:0] wr_log [$];
  int               rd_cyc_log [$];
  logic [DW-1:0]    rd_val_log [$];
  int               done_cnt = 0;
  int               busy_cnt = 0;
  always @(negedge clk_i) begin
    if (ram_we_o) wr_log.push_back({ram_waddr_o, ram_wdata_o});
    if (clear_done_o) done_cnt <= done_cnt + 1;
    if (clear_busy_o) busy_cnt <= busy_cnt + 1;
    if (rd_valid_o) begin
      rd_cyc_log.push_back(cyc);
      rd_val_log.push_back(rd_data_o);
    end
  end

  // Reference state
  logic [DW-1:0]    ref_mem [DEPTH];
  logic             model_last_b;
  logic [AW+DW-1:0] exp_wr [$];
  int               exp_rd_cyc [$];
  logic [DW-1:0]    exp_rd_val [$];
  int               rd_base = 0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          a_req;
    logic          b_req;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] a_data;
    logic [DW-1:0] b_data;
    logic          exp_a_gnt;
    logic          exp_b_gnt;
  } arb_vec_t;

  arb_vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic a_req, input logic [AW-1:0] a_addr, input logic [DW-1:0] a_data,
                               input logic b_req, input logic [AW-1:0] b_addr, input logic [DW-1:0] b_data,
                               input logic rd_req, input logic [AW-1:0] rd_addr, input logic clr);
    a_req_i       = a_req;
    a_addr_i      = a_addr;
    a_data_i      = a_data;
    b_req_i       = b_req;
    b_addr_i      = b_addr;
    b_data_i      = b_data;
    rd_req_i      = rd_req;
    rd_addr_i     = rd_addr;
    clear_start_i = clr;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic setVec(input int i, input logic a, input logic b, input logic ea, input logic eb);
    vecs[i].a_req     = a;
    vecs[i].b_req     = b;
    vecs[i].a_addr    = AW'(16 + i);
    vecs[i].b_addr    = AW'(64 + i);
    vecs[i].a_data    = DW'(7'h40 | i);
    vecs[i].b_data    = DW'(7'h20 | i);
    vecs[i].exp_a_gnt = ea;
    vecs[i].exp_b_gnt = eb;
  endtask

  task automatic doReset();
    idleInputs();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_last_b = 1'b1;
    @(posedge clk_i); #1;
  endtask

  // Requester A alone writes one word; bounded wait for the grant.
  task automatic writeA(input logic [AW-1:0] addr, input logic [DW-1:0] data, input string name);
    logic got;
    got = 1'b0;
    applyStimulus(1'b1, addr, data, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      if (a_gnt_o) got = 1'b1;
      @(posedge clk_i); #1;
    end
    idleInputs();
    checkOutput(name, got, 1);
    if (got) begin
      ref_mem[addr] = data;
      model_last_b  = 1'b0;
    end
  endtask

  task automatic issueRead(input logic [AW-1:0] addr);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, addr, 1'b0);
    @(posedge clk_i); #1;
    exp_rd_cyc.push_back(cyc + 1);
    exp_rd_val.push_back(ref_mem[addr]);
  endtask

  task automatic checkReads(input string name);
    int n_got;
    n_got = rd_val_log.size() - rd_base;
    checkOutput({name, "_count"}, n_got, exp_rd_val.size());
    for (int i = 0; i < exp_rd_val.size() && i < n_got; i++) begin
      checkOutput({name, "_cyc"}, rd_cyc_log[rd_base + i], exp_rd_cyc[i]);
      checkOutput({name, "_data"}, rd_val_log[rd_base + i], exp_rd_val[i]);
    end
    rd_base = rd_val_log.size();
    exp_rd_cyc.delete();
    exp_rd_val.delete();
  endtask

  initial begin
    int wr_base, done_base, busy_base, waited, mism, ia, ib;
    logic gnt_in_clear, got, found, pa, pb, ea, eb, rq;
    logic [AW-1:0] aa, ba, ra;
    logic [DW-1:0] ad, bd, rv;
    logic [5:0] order;

    // Arbitration vectors, starting from the reset arbiter state (A wins first tie)
    setVec(0, 1, 1, 1, 0);
    setVec(1, 1, 1, 0, 1);
    setVec(2, 1, 0, 1, 0);
    setVec(3, 1, 0, 1, 0);
    setVec(4, 0, 1, 0, 1);
    setVec(5, 0, 1, 0, 1);
    setVec(6, 1, 1, 1, 0);
    setVec(7, 0, 0, 0, 0);
    setVec(8, 1, 1, 0, 1);
    setVec(9, 1, 1, 1, 0);

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 7'h7F;

    // Reset state
    idleInputs();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_we", ram_we_o, 0);
    checkOutput("rst_waddr", ram_waddr_o, 0);
    checkOutput("rst_wdata", ram_wdata_o, 0);
    checkOutput("rst_raddr", ram_raddr_o, 0);
    checkOutput("rst_rd_valid", rd_valid_o, 0);
    checkOutput("rst_busy", clear_busy_o, 0);
    checkOutput("rst_done", clear_done_o, 0);
    rst_ni = 1'b1;
    model_last_b = 1'b1;
    @(posedge clk_i); #1;

    // Table-driven arbitration
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a_req, vecs[i].a_addr, vecs[i].a_data,
                    vecs[i].b_req, vecs[i].b_addr, vecs[i].b_data, 1'b0, '0, 1'b0);
      @(negedge clk_i);
      checkOutput($sformatf("vec%0d_a_gnt", i), a_gnt_o, vecs[i].exp_a_gnt);
      checkOutput($sformatf("vec%0d_b_gnt", i), b_gnt_o, vecs[i].exp_b_gnt);
      @(posedge clk_i); #1;
      idleInputs();
      @(negedge clk_i);
      checkOutput($sformatf("vec%0d_we", i), ram_we_o, vecs[i].exp_a_gnt | vecs[i].exp_b_gnt);
      if (vecs[i].exp_a_gnt) begin
        checkOutput($sformatf("vec%0d_waddr", i), ram_waddr_o, vecs[i].a_addr);
        checkOutput($sformatf("vec%0d_wdata", i), ram_wdata_o, vecs[i].a_data);
      end else if (vecs[i].exp_b_gnt) begin
        checkOutput($sformatf("vec%0d_waddr", i), ram_waddr_o, vecs[i].b_addr);
        checkOutput($sformatf("vec%0d_wdata", i), ram_wdata_o, vecs[i].b_data);
      end
      @(posedge clk_i); #1;
    end

    // Clear sweep with A pending throughout and a second start mid-sweep
    wr_base   = wr_log.size();
    done_base = done_cnt;
    busy_base = busy_cnt;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    @(posedge clk_i); #1;
    applyStimulus(1'b1, AW'(5), 7'h2A, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    gnt_in_clear = 1'b0;
    got    = 1'b0;
    waited = 0;
    while (!got && waited < 700) begin
      @(negedge clk_i);
      if (clear_busy_o && a_gnt_o) gnt_in_clear = 1'b1;
      if (!clear_busy_o && a_gnt_o) got = 1'b1;
      @(posedge clk_i); #1;
      waited++;
      clear_start_i = (waited == 100);
    end
    idleInputs();
    checkOutput("clr_gnt_blocked", gnt_in_clear, 0);
    checkOutput("clr_a_granted", got, 1);
    checkOutput("clr_grant_cycle", waited, 513);
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("clr_write_count", wr_log.size() - wr_base, DEPTH + 1);
    mism = 0;
    for (int i = 0; i < DEPTH && (wr_base + i) < wr_log.size(); i++)
      if (wr_log[wr_base + i] !== {AW'(i), 7'h00}) mism++;
    checkOutput("clr_sweep_seq", mism, 0);
    if (wr_log.size() > wr_base + DEPTH)
      checkOutput("clr_pending_write", wr_log[wr_base + DEPTH], {AW'(5), 7'h2A});
    checkOutput("clr_done_pulses", done_cnt - done_base, 1);
    checkOutput("clr_busy_cycles", busy_cnt - busy_base, DEPTH);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_mem[5]   = 7'h2A;
    model_last_b = 1'b0;

    // Reads: back-to-back stream, then read/write collision on one address
    writeA(AW'(10), 7'h11, "rd_setup_wr10");
    @(posedge clk_i); #1;
    issueRead(AW'(10));
    issueRead(AW'(11));
    issueRead(AW'(10));
    issueRead(AW'(5));
    idleInputs();
    repeat (4) @(posedge clk_i);
    #1;
    checkReads("rd_stream");
    applyStimulus(1'b1, AW'(20), 7'h33, 1'b0, '0, '0, 1'b1, AW'(20), 1'b0);
    @(posedge clk_i); #1;
    exp_rd_cyc.push_back(cyc + 1);
    exp_rd_val.push_back(ref_mem[20]);
    ref_mem[20] = 7'h33;
    idleInputs();
    @(posedge clk_i); #1;
    issueRead(AW'(20));
    idleInputs();
    repeat (4) @(posedge clk_i);
    #1;
    checkReads("rd_collide");

    // Both requesters held with three writes each: strict alternation from reset
    doReset();
    wr_base = wr_log.size();
    exp_wr.delete();
    ia = 0;
    ib = 0;
    order = '0;
    for (int k = 0; k < 10 && (ia < 3 || ib < 3); k++) begin
      applyStimulus(ia < 3, AW'(400 + ia), DW'(ia + 1), ib < 3, AW'(450 + ib), DW'(ib + 9), 1'b0, '0, 1'b0);
      @(negedge clk_i);
      if (a_gnt_o) begin
        exp_wr.push_back({AW'(400 + ia), DW'(ia + 1)});
        ref_mem[400 + ia] = DW'(ia + 1);
        ia++;
        order = {order[4:0], 1'b0};
      end else if (b_gnt_o) begin
        exp_wr.push_back({AW'(450 + ib), DW'(ib + 9)});
        ref_mem[450 + ib] = DW'(ib + 9);
        ib++;
        order = {order[4:0], 1'b1};
      end
      @(posedge clk_i); #1;
    end
    idleInputs();
    checkOutput("alt_order", order, 6'b010101);
    model_last_b = order[0];

    // Randomized traffic against the reference model
    pa = 1'b0;
    pb = 1'b0;
    aa = '0; ba = '0; ad = '0; bd = '0;
    for (int k = 0; k < 200; k++) begin
      if (!pa && $urandom_range(1, 0) == 1) begin
        pa = 1'b1; aa = AW'($urandom); ad = DW'($urandom);
      end
      if (!pb && $urandom_range(1, 0) == 1) begin
        pb = 1'b1; ba = AW'($urandom); bd = DW'($urandom);
      end
      rq = ($urandom_range(1, 0) == 1);
      ra = AW'($urandom);
      applyStimulus(pa, aa, ad, pb, ba, bd, rq, ra, 1'b0);
      ea = pa && (!pb || model_last_b);
      eb = pb && !ea;
      @(negedge clk_i);
      checkOutput("rand_a_gnt", a_gnt_o, ea);
      checkOutput("rand_b_gnt", b_gnt_o, eb);
      rv = ref_mem[ra];
      if (ea) begin
        exp_wr.push_back({aa, ad}); ref_mem[aa] = ad; model_last_b = 1'b0; pa = 1'b0;
      end else if (eb) begin
        exp_wr.push_back({ba, bd}); ref_mem[ba] = bd; model_last_b = 1'b1; pb = 1'b0;
      end
      @(posedge clk_i); #1;
      if (rq) begin
        exp_rd_cyc.push_back(cyc + 1);
        exp_rd_val.push_back(rv);
      end
    end
    idleInputs();
    repeat (4) @(posedge clk_i);
    #1;
    checkOutput("rand_write_count", wr_log.size() - wr_base, exp_wr.size());
    mism = 0;
    for (int i = 0; i < exp_wr.size() && (wr_base + i) < wr_log.size(); i++)
      if (wr_log[wr_base + i] !== exp_wr[i]) mism++;
    checkOutput("rand_write_seq", mism, 0);
    checkReads("rand_rd");

    // Reset in the middle of a sweep
    writeA(AW'(300), 7'h55, "mid_setup_wr300");
    writeA(AW'(150), 7'h66, "mid_setup_wr150");
    done_base = done_cnt;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    @(posedge clk_i); #1;
    idleInputs();
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk_i);
      if (ram_we_o && ram_waddr_o == AW'(200)) found = 1'b1;
    end
    checkOutput("mid_reached_200", found, 1);
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("mid_rst_we", ram_we_o, 0);
    checkOutput("mid_rst_waddr", ram_waddr_o, 0);
    checkOutput("mid_rst_busy", clear_busy_o, 0);
    checkOutput("mid_rst_done", clear_done_o, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    for (int i = 0; i < 200; i++) ref_mem[i] = '0;
    repeat (20) @(posedge clk_i);
    #1;
    checkOutput("mid_no_done", done_cnt - done_base, 0);
    checkOutput("mid_idle_after", clear_busy_o, 0);
    issueRead(AW'(300));
    issueRead(AW'(150));
    issueRead(AW'(199));
    issueRead(AW'(200));
    idleInputs();
    repeat (4) @(posedge clk_i);
    #1;
    checkReads("mid_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
